rsa_keypair_gen: RTL
====================

Name: rsa_keypair_gen

Overview:
Parametrised successor to the 8-bit public-exponent generator. Given primes p and q, it computes n = p*q and phi = (p-1)*(q-1). It then searches odd candidates e upward from E_START for gcd(e, phi) = 1 and returns the private exponent d = e^-1 mod phi, using extended Euclid in the same pass. It feeds the encryptor/decryptor key registers and flags degenerate inputs instead of hanging.

Parameters:
WIDTH, 8, bit width of p and q; n, phi, e and d are 2*WIDTH bits
E_START, 3, first candidate exponent; must be odd and >= 3 (elaboration error otherwise)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
start  in  1  request; accepted only in IDLE
p  in  WIDTH  prime p, sampled on the accepting edge
q  in  WIDTH  prime q, sampled on the accepting edge
busy  out  1  high from the cycle after acceptance until done
done  out  1  one-cycle pulse at completion (success or error)
err  out  1  valid with done; held until next accepted start
n  out  2*WIDTH  p*q
e  out  2*WIDTH  public exponent
d  out  2*WIDTH  private exponent

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE. busy, done, err, n, e and d are all 0. Reset overrides everything, including mid-search; a start in the same cycle is dropped.
- IDLE: start=1 latches p and q and moves to PHI. Start is ignored in all other states; p and q changes after acceptance have no effect.
- PHI (1 cycle): register n = p*q and phi = (p-1)*(q-1), both full 2*WIDTH products. Set cand = E_START.
  - If p<2 or q<2 (phi==0), or phi <= E_START: go to FAIL.
  - Otherwise go to LOAD.
- LOAD (1 cycle): r0=phi, r1=cand, t0=0, t1=1. The t registers are signed, 2*WIDTH+1 bits.
- STEP (1 cycle per Euclid iteration): while r1 != 0, with qt = r0 / r1 (combinational unsigned divide):
  - r0 <= r1 and r1 <= r0 - qt*r1;
  - t0 <= t1 and t1 <= t0 - qt*t1.
  - When r1 == 0 on entry, go to EVAL.
- EVAL (1 cycle):
  - If r0 == 1: e <= cand; d <= t0 if t0 >= 0, else t0 + phi (d always in [1, phi-1]); go to FIN.
  - Else cand <= cand + 2. If cand + 2 >= phi, go to FAIL; else go to LOAD.
- FIN: done=1 and err=0 for exactly one cycle, then IDLE.
- FAIL: done=1 and err=1 for one cycle; e and d are forced to 0, n stays valid; then IDLE.
- busy is 1 in PHI, LOAD, STEP and EVAL, and 0 in IDLE, FIN and FAIL.
- n, e and d are stable from done until the next accepted start, when they all clear to 0. err clears on that same edge.
- Each candidate costs 3 + k cycles, where k = number of Euclid iterations. There is no internal timeout: termination is guaranteed because cand strictly increases toward phi.
- Arithmetic:
  - qt*r1 <= r0, so no overflow at 2*WIDTH.
  - |t| <= phi throughout, so 2*WIDTH+1 signed bits suffice.
  - cand + 2 is computed at 2*WIDTH+1 bits so the wrap check holds at the maximum phi.
- Non-prime p or q is not detected; the block still returns a valid inverse modulo the computed phi.

Test Plan:
- WIDTH=8, p=3, q=5 -> n=15, e=3, d=3, err=0. done pulses exactly one cycle; busy low the same cycle.
- p=11, q=13 -> n=143. Candidates 3 and 5 are rejected (gcd 3 and gcd 5); result e=7, d=103. Check 7*103 mod 120 = 1.
- p=61, q=53 -> n=3233, e=7, d=1783. Repeat with WIDTH=16, p=251, q=241: the check against a reference model (e*d mod phi == 1, gcd == 1) must pass.
- Error cases: p=1, q=7 (phi=0) -> done and err, e=d=0, n=7. p=2, q=2 (phi=1) -> err. p=2, q=3 (phi=2 <= 3) -> err.
- Hold start high through a whole run and pulse start mid-search -> only one result. Outputs unchanged until start is re-sampled in IDLE; outputs clear on that acceptance.
- Drive rst_n=0 for one cycle during STEP of the p=11, q=13 run -> all outputs 0, IDLE next cycle. A new start with p=3, q=5 must then complete normally with e=3, d=3.

Source files
------------

// File: rtl/rsa_keypair_gen.sv
// RSA key-pair generator: from primes p and q, derive n = p*q and
// phi = (p-1)*(q-1), search odd public exponents e upward from E_START until
// gcd(e, phi) = 1, and return d = e^-1 mod phi from the same extended-Euclid
// pass. Degenerate inputs finish with err instead of hanging.
module rsa_keypair_gen #(
  parameter int WIDTH   = 8,
  parameter int E_START = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   p,
  input  logic [WIDTH-1:0]   q,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2*WIDTH-1:0] n,
  output logic [2*WIDTH-1:0] e,
  output logic [2*WIDTH-1:0] d
);

  localparam int W2 = 2 * WIDTH;

  // An even or too-small starting exponent can never be a valid RSA e.
  if (E_START < 3 || (E_START % 2) == 0) begin : g_bad_estart
    $error("rsa_keypair_gen: E_START must be odd and >= 3");
  end

  typedef enum logic [2:0] {IDLE, PHI, LOAD, STEP, EVAL, FIN, FAIL} state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0]     pr, qr;
  logic [W2-1:0]        phi, cand, r0, r1;
  logic signed [W2:0]   t0, t1;

  // Combinational helpers
  logic [WIDTH-1:0]     pm1, qm1;
  logic [W2-1:0]        n_c, phi_c, qt, r1_nx;
  logic signed [W2:0]   qt_s, t1_nx, phi_s, d_c;
  logic [W2:0]          cand2;
  logic                 degen, r0_one;

  // Products, Euclid step and candidate advance for the current registers.
  // cand2 carries one extra bit so the end-of-search test cannot wrap.
  always_comb begin
    pm1    = pr - WIDTH'(1);
    qm1    = qr - WIDTH'(1);
    n_c    = {{WIDTH{1'b0}}, pr} * {{WIDTH{1'b0}}, qr};
    phi_c  = {{WIDTH{1'b0}}, pm1} * {{WIDTH{1'b0}}, qm1};
    degen  = (pr < WIDTH'(2)) || (qr < WIDTH'(2)) || (phi_c <= W2'(E_START));
    qt     = (r1 == '0) ? '0 : (r0 / r1);
    r1_nx  = r0 - qt * r1;
    qt_s   = signed'({1'b0, qt});
    t1_nx  = t0 - qt_s * t1;
    phi_s  = signed'({1'b0, phi});
    d_c    = t0[W2] ? (t0 + phi_s) : t0;
    cand2  = {1'b0, cand} + (W2+1)'(2);
    r0_one = (r0 == W2'(1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and status outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = PHI;
      PHI: begin
        busy     = 1'b1;
        state_nx = degen ? FAIL : LOAD;
      end
      LOAD: begin
        busy     = 1'b1;
        state_nx = STEP;
      end
      STEP: begin
        busy = 1'b1;
        if (r1 == '0) state_nx = EVAL;
      end
      EVAL: begin
        busy = 1'b1;
        if (r0_one)                      state_nx = FIN;
        else if (cand2 >= {1'b0, phi})   state_nx = FAIL;
        else                             state_nx = LOAD;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      FAIL: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, Euclid registers and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pr   <= '0;
      qr   <= '0;
      phi  <= '0;
      cand <= '0;
      r0   <= '0;
      r1   <= '0;
      t0   <= '0;
      t1   <= '0;
      n    <= '0;
      e    <= '0;
      d    <= '0;
      err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pr  <= p;
          qr  <= q;
          n   <= '0;
          e   <= '0;
          d   <= '0;
          err <= 1'b0;
        end
        PHI: begin
          n    <= n_c;
          phi  <= phi_c;
          cand <= W2'(E_START);
          if (degen) err <= 1'b1;
        end
        LOAD: begin
          r0 <= phi;
          r1 <= cand;
          t0 <= '0;
          t1 <= (W2+1)'(1);
        end
        STEP: if (r1 != '0) begin
          r0 <= r1;
          r1 <= r1_nx;
          t0 <= t1;
          t1 <= t1_nx;
        end
        EVAL: begin
          if (r0_one) begin
            e <= cand;
            d <= d_c[W2-1:0];
          end else begin
            cand <= cand2[W2-1:0];
            if (cand2 >= {1'b0, phi}) err <= 1'b1;
          end
        end
        FAIL: begin
          e <= '0;
          d <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
